instr_mem_loader: RTL and testbench

Write-side companion to the instruction fetch path: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and drives a single-cycle write port into the instruction memory bank at byte addresses stepping by 4 from a programmable base. It matches the fetch side's PC addressing, so a program can be loaded at run time instead of only from the initial memory image. It sits between a host/serial byte source and the instruction memory write port.

---
 rtl/instr_mem_loader.sv | 156 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - packs a byte stream into 32-bit words and writes them to instruction memory
module instr_mem_loader #(
    parameter int DEPTH = 256,
    parameter int LEN_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic [LEN_W-1:0] i_load_len,
    input  logic [7:0]       i_byte_in,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_base;
    logic [LEN_W-1:0] r_len;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_word;
    logic             r_byte_ready;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_words_written;

    logic             w_accept;
    logic [LEN_W-1:0] w_len_clamped;
    logic [LEN_W-1:0] w_count_next;
    logic             w_last_word;
    logic [31:0]      w_word_offset;

    // r_byte_ready is high exactly in RECV, so it doubles as the accept qualifier
    assign w_accept      = r_byte_ready && i_byte_valid;
    assign w_len_clamped = (i_load_len > DEPTH_L) ? DEPTH_L : i_load_len;
    assign w_count_next  = r_words_written + LEN_W'(1);
    assign w_last_word   = (w_count_next == r_len);
    // Byte offset of the current word; the add below wraps mod 2^32
    assign w_word_offset = {{(32 - LEN_W - 2){1'b0}}, r_words_written, 2'b00};

    // Next-state decision for the load sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (w_len_clamped == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath and registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base          <= '0;
            r_len           <= '0;
            r_byte_idx      <= '0;
            r_word          <= '0;
            r_byte_ready    <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_byte_ready <= (w_next == S_RECV);
            r_mem_we     <= (w_next == S_WRITE);
            r_busy       <= (w_next == S_RECV) || (w_next == S_WRITE);
            r_done       <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base          <= i_base_addr;
                        r_len           <= w_len_clamped;
                        r_words_written <= '0;
                        r_byte_idx      <= '0;
                        r_word          <= '0;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= i_byte_in;
                            2'd1: r_word[15:8]  <= i_byte_in;
                            2'd2: r_word[23:16] <= i_byte_in;
                            default: begin
                                // Fourth byte completes the word straight into the write port
                                r_mem_addr  <= r_base + w_word_offset;
                                r_mem_wdata <= {i_byte_in, r_word};
                                r_word      <= '0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_words_written <= w_count_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_byte_ready    = r_byte_ready;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_words_written = r_words_written;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [8:0]  load_len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [8:0]  words_written;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_seen_cyc = 0;
    int done_cnt = 0;
    int ready_viol = 0;
    int done_before;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  bytes3[12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'haa, 8'hbb,
                                8'hcc, 8'hdd, 8'hde, 8'had, 8'hbe, 8'hef};

    instr_mem_loader #(.DEPTH(256), .LEN_W(9)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_load_len      (load_len),
        .i_byte_in       (byte_in),
        .i_byte_valid    (byte_valid),
        .o_byte_ready    (byte_ready),
        .o_mem_we        (mem_we),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .o_busy          (busy),
        .o_done          (done),
        .o_words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            last_we_cyc = cyc;
            if (byte_ready) ready_viol++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("byte_ready_wait", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] b, input logic [8:0] l);
        start = 1'b1;
        base_addr = b;
        load_len = l;
        @(negedge clk);
        start = 1'b0;
        base_addr = 32'hdead_beef;
        load_len = 9'd7;
    endtask

    task automatic wait_done(input int limit);
        int t;
        t = 0;
        while (!done && t < limit) begin
            @(negedge clk);
            t++;
        end
        done_seen_cyc = cyc;
        chk("done_wait", {31'b0, done}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, byte_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ww", {23'b0, words_written}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word, back-to-back bytes
        start_load(32'h0, 9'd1);
        chk("t1_ready_T1", {31'b0, byte_ready}, 32'd1);
        chk("t1_busy_T1", {31'b0, busy}, 32'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        wait_done(20);
        chk("t1_nwr", wr_addr.size(), 32'd1);
        chk("t1_addr", wr_addr[0], 32'h0);
        chk("t1_data", wr_data[0], 32'h0050_0013);
        chk("t1_done_lat", done_seen_cyc, last_we_cyc + 1);
        chk("t1_ww", {23'b0, words_written}, 32'd1);
        chk("t1_busy_done", {31'b0, busy}, 32'd0);

        // Back-to-back load with stalls and an ignored start mid-load
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start_load(32'h40, 9'd3);
        chk("t3_ww_restart", {23'b0, words_written}, 32'd0);
        chk("t3_busy", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            send_byte(bytes3[k], int'($urandom_range(0, 2)));
            if (k == 4) begin
                start_load(32'h1000, 9'd5);
            end
        end
        wait_done(30);
        chk("t3_nwr", wr_addr.size(), 32'd3);
        chk("t3_addr0", wr_addr[0], 32'h40);
        chk("t3_addr1", wr_addr[1], 32'h44);
        chk("t3_addr2", wr_addr[2], 32'h48);
        chk("t3_data0", wr_data[0], 32'h0403_0201);
        chk("t3_data1", wr_data[1], 32'hddcc_bbaa);
        chk("t3_data2", wr_data[2], 32'hefbe_adde);
        chk("t3_ready_in_write", ready_viol, 32'd0);
        chk("t3_ww", {23'b0, words_written}, 32'd3);
        @(negedge clk);
        chk("t3_done_pulse", {31'b0, done}, 32'd0);
        chk("t3_ww_hold", {23'b0, words_written}, 32'd3);
        chk("t3_addr_hold", mem_addr, 32'h48);

        // Zero-length load
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start_load(32'h500, 9'd0);
        chk("t4_done_T1", {31'b0, done}, 32'd1);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_ww", {23'b0, words_written}, 32'd0);
        @(negedge clk);
        chk("t4_done_off", {31'b0, done}, 32'd0);
        chk("t4_nwr", wr_addr.size(), 32'd0);

        // Address wrap
        @(negedge clk);
        start_load(32'hffff_fffc, 9'd2);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        send_byte(8'h50, 0);
        send_byte(8'h60, 0);
        send_byte(8'h70, 0);
        send_byte(8'h80, 0);
        wait_done(20);
        chk("t5_nwr", wr_addr.size(), 32'd2);
        chk("t5_addr0", wr_addr[0], 32'hffff_fffc);
        chk("t5_addr1", wr_addr[1], 32'h0000_0000);
        chk("t5_data0", wr_data[0], 32'h4030_2010);
        chk("t5_data1", wr_data[1], 32'h8070_6050);

        // Length clamp: 300 requested, 256 written
        @(negedge clk);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start_load(32'h2000, 9'd300);
        for (int k = 0; k < 1024; k++) begin
            send_byte(k[7:0], 0);
        end
        wait_done(20);
        chk("t6_nwr", wr_addr.size(), 32'd256);
        chk("t6_last_addr", wr_addr[255], 32'h0000_23fc);
        chk("t6_last_data", wr_data[255], 32'hfffe_fdfc);
        chk("t6_first_data", wr_data[0], 32'h0302_0100);
        chk("t6_ww", {23'b0, words_written}, 32'd256);
        chk("t6_not_ready", {31'b0, byte_ready}, 32'd0);

        // Asynchronous reset mid-word
        @(negedge clk);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start_load(32'h80, 9'd1);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        done_before = done_cnt;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t7_ready", {31'b0, byte_ready}, 32'd0);
        chk("t7_busy", {31'b0, busy}, 32'd0);
        chk("t7_addr", mem_addr, 32'd0);
        chk("t7_wdata", mem_wdata, 32'd0);
        chk("t7_ww", {23'b0, words_written}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_no_done", done_cnt, done_before);
        chk("t7_no_write", wr_addr.size(), 32'd0);
        start_load(32'h80, 9'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_done(20);
        chk("t7_nwr", wr_addr.size(), 32'd1);
        chk("t7_new_addr", wr_addr[0], 32'h80);
        chk("t7_new_data", wr_data[0], 32'h0403_0201);
        chk("t7_new_ww", {23'b0, words_written}, 32'd1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
